// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle between the MEM pipeline stage, the data-memory controller
// and the external 16-bit SRAM. The controller uses the slave view; the
// pipeline/SRAM side (or a testbench) uses the master view.
`timescale 1ns/1ps
interface mem_stage_sram_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] SRAM_DQ_OUT;
  logic        SRAM_DQ_OE;
  logic [15:0] SRAM_DQ_IN;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, write_data, SRAM_DQ_IN,
    output read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, address, write_data, SRAM_DQ_IN,
    input  read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller. Each 32-bit load/store is split into a
// low and a high 16-bit SRAM phase of SRAM_WAIT cycles each, followed by a
// single DONE cycle in which ready releases the pipeline freeze.
// SRAM-side outputs are registered from next-state values so they line up
// with the current state without a cycle of lag.
`timescale 1ns/1ps
module mem_stage_sram_ctrl #(
  parameter int unsigned MEM_BASE  = 1024,
  parameter int unsigned SRAM_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus
);

  localparam int unsigned CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [31:0]   BASE_W   = 32'(MEM_BASE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [15:0]   rd_lo_q, rd_lo_d;
  logic [31:0]   read_data_q, read_data_d;
  logic [17:0]   sram_addr_q, sram_addr_d;
  logic          we_n_q, we_n_d;
  logic          oe_q, oe_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          req_s;
  logic          last_s;
  logic          phase_s;

  // Byte address to SRAM word index; out-of-range addresses wrap in 17 bits.
  function automatic logic [16:0] addr_to_word(input logic [31:0] addr);
    return 17'((addr - BASE_W) >> 2);
  endfunction

  assign req_s  = bus.MEM_R_EN | bus.MEM_W_EN;
  assign last_s = (cnt_q == CNT_LAST);

  assign bus.ready       = (state_q == DONE) || ((state_q == IDLE) && !req_s);
  assign bus.read_data   = read_data_q;
  assign bus.SRAM_ADDR   = sram_addr_q;
  assign bus.SRAM_WE_N   = we_n_q;
  assign bus.SRAM_DQ_OE  = oe_q;
  assign bus.SRAM_DQ_OUT = dq_out_q;

  // Access sequencing: request latch, phase counter and read-data assembly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    rd_lo_d     = rd_lo_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = LOW;
          cnt_d   = CNT_ZERO;
          word_d  = addr_to_word(bus.address);
          wdata_d = bus.write_data;
          wr_d    = bus.MEM_W_EN;   // write wins when both enables are set
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          state_d = HIGH;
          cnt_d   = CNT_ZERO;
          if (!wr_q) begin
            rd_lo_d = bus.SRAM_DQ_IN;
          end else begin
            rd_lo_d = rd_lo_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (last_s) begin
          state_d = DONE;
          cnt_d   = CNT_ZERO;
          if (!wr_q) begin
            read_data_d = {bus.SRAM_DQ_IN, rd_lo_q};
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // SRAM pin values for the upcoming cycle; WE_N rises on each phase's last cycle for hold.
  always_comb begin
    sram_addr_d = sram_addr_q;
    we_n_d      = 1'b1;
    oe_d        = 1'b0;
    dq_out_d    = dq_out_q;
    phase_s     = (state_d == LOW) || (state_d == HIGH);
    if (phase_s) begin
      sram_addr_d = {word_d, (state_d == HIGH)};
      if (wr_d) begin
        oe_d     = 1'b1;
        we_n_d   = (cnt_d == CNT_LAST);
        dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
      end else begin
        oe_d   = 1'b0;
        we_n_d = 1'b1;
      end
    end else begin
      sram_addr_d = sram_addr_q;
    end
  end

  // State and output registers with synchronous reset (aborts any access).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      word_q      <= 17'd0;
      wdata_q     <= 32'd0;
      wr_q        <= 1'b0;
      rd_lo_q     <= 16'd0;
      read_data_q <= 32'd0;
      sram_addr_q <= 18'd0;
      we_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      dq_out_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_lo_q     <= rd_lo_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_q        <= oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Testbench for mem_stage_sram_ctrl: behavioural SRAM plus a word-level
// reference memory; directed scenarios followed by random loads/stores.
`timescale 1ns/1ps
module tb_mem_stage_sram_ctrl;
  localparam int unsigned BASE = 1024;
  localparam int unsigned W    = 3;
  localparam int unsigned LAT  = 2 * W + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_stage_sram_ctrl_if bus();

  mem_stage_sram_ctrl #(.MEM_BASE(BASE), .SRAM_WAIT(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External SRAM: asynchronous read, write on clock edge while WE_N is low.
  logic [15:0] sram [0:262143];
  always @(posedge clk) begin
    if (!bus.SRAM_WE_N && bus.SRAM_DQ_OE) sram[bus.SRAM_ADDR] <= bus.SRAM_DQ_OUT;
  end
  assign bus.SRAM_DQ_IN = sram[bus.SRAM_ADDR];

  // Reference: 32-bit words indexed by word number.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    bus.MEM_W_EN   = wr;
    bus.MEM_R_EN   = rd;
    bus.address    = a;
    bus.write_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    step();
  endtask

  // One access; returns observed timing and pin activity. Request stays applied afterwards.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int we_low, output int oe_cnt,
                        output logic [17:0] a_lo, output logic [17:0] a_hi,
                        output logic [31:0] rdata);
    int c;
    drive(wr, rd, a, d);
    we_low = 0; oe_cnt = 0; a_lo = 18'd0; a_hi = 18'd0; c = 0;
    forever begin
      @(negedge clk);
      if (bus.ready) break;
      if (c == 1)     a_lo = bus.SRAM_ADDR;
      if (c == W + 1) a_hi = bus.SRAM_ADDR;
      if (!bus.SRAM_WE_N) we_low++;
      if (bus.SRAM_DQ_OE) oe_cnt++;
      c++;
      if (c > 100) break;
      step();
    end
    lat   = c;
    rdata = bus.read_data;
    step();
  endtask

  int          lat, we_low, oe_cnt;
  logic [17:0] a_lo, a_hi;
  logic [31:0] rdata, dat, addr;
  int unsigned wd;
  logic        iswr;

  initial begin
    last_rd = 32'd0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step(); step();
    @(negedge clk);
    check("rst_read_data", bus.read_data, 32'd0);
    check("rst_sram_addr", 32'(bus.SRAM_ADDR), 32'd0);
    check("rst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
    check("rst_oe", 32'(bus.SRAM_DQ_OE), 32'd0);
    check("rst_dq_out", 32'(bus.SRAM_DQ_OUT), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    step();
    rst = 1'b0;

    // Store 0xDEADBEEF @BASE.
    access(1'b1, 1'b0, BASE, 32'hDEADBEEF, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
    check("t1_latency", 32'(lat), 32'(LAT));
    check("t1_we_low", 32'(we_low), 32'(2 * (W - 1)));
    check("t1_oe_cycles", 32'(oe_cnt), 32'(2 * W));
    check("t1_addr_lo", 32'(a_lo), 32'd0);
    check("t1_addr_hi", 32'(a_hi), 32'd1);
    check("t1_half0", 32'(sram[0]), 32'h0000BEEF);
    check("t1_half1", 32'(sram[1]), 32'h0000DEAD);
    check("t1_read_data", rdata, 32'd0);
    ref_mem[0] = 32'hDEADBEEF;
    idle();

    // Load @BASE.
    access(1'b0, 1'b1, BASE, 32'd0, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
    last_rd = ref_mem[0];
    check("t2_latency", 32'(lat), 32'(LAT));
    check("t2_read_data", rdata, last_rd);
    check("t2_we_low", 32'(we_low), 32'd0);
    check("t2_oe_cycles", 32'(oe_cnt), 32'd0);
    idle();

    // Store @BASE+8, then a load held straight into the next cycle.
    access(1'b1, 1'b0, BASE + 8, 32'h12345678, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
    check("t3_addr_lo", 32'(a_lo), 32'd4);
    check("t3_addr_hi", 32'(a_hi), 32'd5);
    check("t3_half4", 32'(sram[4]), 32'h00005678);
    check("t3_half5", 32'(sram[5]), 32'h00001234);
    ref_mem[2] = 32'h12345678;
    access(1'b0, 1'b1, BASE + 8, 32'd0, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
    last_rd = ref_mem[2];
    check("t4_chained_latency", 32'(lat), 32'(LAT));
    check("t4_read_data", rdata, last_rd);
    idle();

    // Both enables: behaves as a write, read_data untouched.
    access(1'b1, 1'b1, BASE + 4, 32'h0000A5A5, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
    check("t6_read_data_kept", rdata, last_rd);
    check("t6_half2", 32'(sram[2]), 32'h0000A5A5);
    check("t6_half3", 32'(sram[3]), 32'h00000000);
    ref_mem[1] = 32'h0000A5A5;
    idle();

    // Address below MEM_BASE wraps to the top word.
    access(1'b1, 1'b0, BASE - 4, 32'hCAFEF00D, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
    check("wrap_addr_lo", 32'(a_lo), 32'h0003FFFE);
    check("wrap_addr_hi", 32'(a_hi), 32'h0003FFFF);
    ref_mem[32'h1FFFF] = 32'hCAFEF00D;
    access(1'b0, 1'b1, BASE - 4, 32'd0, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
    last_rd = ref_mem[32'h1FFFF];
    check("wrap_read_data", rdata, last_rd);
    idle();

    // Reset during the high phase of a store.
    drive(1'b1, 1'b0, BASE + 400, 32'h11112222);
    repeat (5) step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    @(negedge clk);
    check("t5_we_n", 32'(bus.SRAM_WE_N), 32'd1);
    check("t5_oe", 32'(bus.SRAM_DQ_OE), 32'd0);
    check("t5_sram_addr", 32'(bus.SRAM_ADDR), 32'd0);
    check("t5_read_data", bus.read_data, 32'd0);
    check("t5_ready", 32'(bus.ready), 32'd1);
    step();
    rst = 1'b0;
    last_rd = 32'd0;

    // Random loads/stores against the word-level reference.
    for (int i = 0; i < 40; i++) begin
      wd   = $urandom_range(0, 15);
      iswr = ($urandom_range(0, 1) == 1) || !ref_mem.exists(wd);
      dat  = $urandom;
      addr = BASE + wd * 4 + $urandom_range(0, 3);
      access(iswr, !iswr, addr, dat, lat, we_low, oe_cnt, a_lo, a_hi, rdata);
      check("rnd_latency", 32'(lat), 32'(LAT));
      check("rnd_addr_lo", 32'(a_lo), wd * 2);
      if (iswr) begin
        ref_mem[wd] = dat;
        check("rnd_wr_we_low", 32'(we_low), 32'(2 * (W - 1)));
        check("rnd_wr_sram", {sram[wd * 2 + 1], sram[wd * 2]}, dat);
        check("rnd_wr_read_data_kept", rdata, last_rd);
      end else begin
        last_rd = ref_mem[wd];
        check("rnd_rd_data", rdata, last_rd);
        check("rnd_rd_we_low", 32'(we_low), 32'd0);
      end
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
